// File: rtl/blinkt_frame_sequencer.sv
// rtl/blinkt_frame_sequencer.sv - APA102/Blinkt frame sequencer with write-anytime shadow pixel registers
// Snapshots shadow pixels on start, then shifts start frame, LED frames and end frame MSB first.
module blinkt_frame_sequencer #(
   parameter int NUM_LEDS = 8,
   parameter int CLK_DIV  = 4,
   parameter int END_BITS = 32,
   localparam int ADDR_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              serial_clk,
   output logic              serial_data
);

   localparam int PH_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int MAX_BITS = (END_BITS > 32) ? END_BITS : 32;
   localparam int BIT_W    = $clog2(MAX_BITS);

   typedef enum logic [1:0] {IDLE, START_FRM, LED_FRM, END_FRM} state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [ADDR_W-1:0] led_q, led_d;
   logic              sclk_q, sclk_d;
   logic              sdata_q, sdata_d;
   logic              pending_q, pending_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [31:0]       shadow_q [NUM_LEDS];
   logic [31:0]       shadow_d [NUM_LEDS];
   logic [31:0]       active_q [NUM_LEDS];
   logic [31:0]       active_d [NUM_LEDS];
   logic [31:0]       tx_word;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      led_d     = led_q;
      sclk_d    = sclk_q;
      sdata_d   = sdata_q;
      pending_d = pending_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      shadow_d  = shadow_q;
      active_d  = active_q;
      tx_word   = '0;

      // Out-of-range addresses match no slot and are dropped.
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (wr_en && (wr_addr == ADDR_W'(i))) begin
            shadow_d[i] = wr_data;
         end
      end

      case (state_q)
         IDLE: begin
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
            phase_d = '0;
            bit_d   = '0;
            led_d   = '0;
            if (start || pending_q) begin
               state_d   = START_FRM;
               active_d  = shadow_q;
               pending_d = 1'b0;
               busy_d    = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         default: begin
            if (start) begin
               pending_d = 1'b1;
            end
            if (phase_q == PH_W'(CLK_DIV - 1)) begin
               phase_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // End of the high phase: move to the next bit position.
                  sclk_d = 1'b0;
                  case (state_q)
                     START_FRM: begin
                        if (bit_q == BIT_W'(31)) begin
                           state_d = LED_FRM;
                           bit_d   = '0;
                           led_d   = '0;
                        end else begin
                           bit_d = bit_q + BIT_W'(1);
                        end
                     end
                     LED_FRM: begin
                        if (bit_q == BIT_W'(31)) begin
                           bit_d = '0;
                           if (led_q == ADDR_W'(NUM_LEDS - 1)) begin
                              state_d = END_FRM;
                              led_d   = '0;
                           end else begin
                              led_d = led_q + ADDR_W'(1);
                           end
                        end else begin
                           bit_d = bit_q + BIT_W'(1);
                        end
                     end
                     default: begin
                        if (bit_q == BIT_W'(END_BITS - 1)) begin
                           state_d = IDLE;
                           bit_d   = '0;
                           done_d  = 1'b1;
                           busy_d  = pending_q || start;
                        end else begin
                           bit_d = bit_q + BIT_W'(1);
                        end
                     end
                  endcase

                  tx_word = {3'b111, active_q[led_d][28:0]};
                  case (state_d)
                     LED_FRM: sdata_d = tx_word[~bit_d[4:0]];
                     END_FRM: sdata_d = 1'b1;
                     default: sdata_d = 1'b0;
                  endcase
               end
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         bit_q     <= '0;
         led_q     <= '0;
         sclk_q    <= 1'b0;
         sdata_q   <= 1'b0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < NUM_LEDS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         led_q     <= led_d;
         sclk_q    <= sclk_d;
         sdata_q   <= sdata_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign serial_clk  = sclk_q;
   assign serial_data = sdata_q;

endmodule

// File: tb/tb_blinkt_frame_sequencer.sv
// tb/tb_blinkt_frame_sequencer.sv - directed self-checking bench for blinkt_frame_sequencer
module tb_blinkt_frame_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        wr_en, start, busy, done, sclk, sdata;
   logic [2:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_en6, start6, busy6, done6, sclk6, sdata6;
   logic [2:0]  wr_addr6;
   logic [31:0] wr_data6;

   int n_cmp = 0;
   int n_bad = 0;

   blinkt_frame_sequencer #(.NUM_LEDS(8), .CLK_DIV(2), .END_BITS(32)) u_dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .busy(busy), .done(done), .serial_clk(sclk), .serial_data(sdata)
   );

   blinkt_frame_sequencer #(.NUM_LEDS(6), .CLK_DIV(1), .END_BITS(32)) u_dut6 (
      .clk(clk), .reset(reset), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
      .start(start6), .busy(busy6), .done(done6), .serial_clk(sclk6), .serial_data(sdata6)
   );

   logic bits[$];
   int   done_cyc[$];
   int   cyc = 0, busy_rise = -1, busy_drops = 0;
   logic sclk_prev = 1'b0, busy_prev = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (sclk === 1'b1 && sclk_prev === 1'b0) bits.push_back(sdata);
      if (busy === 1'b1 && busy_prev === 1'b0) busy_rise = cyc;
      if (busy === 1'b0 && busy_prev === 1'b1) busy_drops++;
      if (done === 1'b1) done_cyc.push_back(cyc);
      sclk_prev = sclk;
      busy_prev = busy;
   end

   logic bits6[$];
   int   done6_n = 0, notoggle6 = 0, busy6_cycles = 0;
   logic sclk6_prev = 1'b0, busy6_prev = 1'b0;

   always @(negedge clk) begin
      if (sclk6 === 1'b1 && sclk6_prev === 1'b0) bits6.push_back(sdata6);
      if (busy6 === 1'b1 && busy6_prev === 1'b1 && sclk6 === sclk6_prev) notoggle6++;
      if (busy6 === 1'b1) busy6_cycles++;
      if (done6 === 1'b1) done6_n++;
      sclk6_prev = sclk6;
      busy6_prev = busy6;
   end

   function automatic logic [31:0] word_at(input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r = {r[30:0], (w * 32 + i < bits.size()) ? bits[w * 32 + i] : 1'bx};
      return r;
   endfunction

   function automatic logic [31:0] word6_at(input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r = {r[30:0], (w * 32 + i < bits6.size()) ? bits6[w * 32 + i] : 1'bx};
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic write_px(input logic [2:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic write_px6(input logic [2:0] a, input logic [31:0] d);
      wr_en6 = 1'b1; wr_addr6 = a; wr_data6 = d;
      @(posedge clk); #1;
      wr_en6 = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int count, input int budget);
      int n;
      n = 0;
      while (done_cyc.size() < count && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_done", done_cyc.size(), count);
   endtask

   initial begin
      int n;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
      wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0; start6 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sclk", sclk, 0);
      check("rst_sdata", sdata, 0);
      reset = 1'b0;

      // Single frame at CLK_DIV=2 with one bright red/blue pixel.
      write_px(3'd0, 32'h1F0000FF);
      bits.delete(); done_cyc.delete();
      pulse_start();
      wait_done(1, 3000);
      check("t1_busy_at_done", busy, 0);
      check("t1_edges", bits.size(), 320);
      check("t1_start_frm", word_at(0), 32'h0000_0000);
      check("t1_led0", word_at(1), 32'hFF0000FF);
      for (int w = 2; w <= 8; w++) check($sformatf("t1_led%0d", w - 1), word_at(w), 32'hE000_0000);
      check("t1_end_frm", word_at(9), 32'hFFFF_FFFF);
      check("t1_len", (done_cyc.size() > 0) ? done_cyc[0] - busy_rise : -1, 1280);
      @(posedge clk); #1;

      // Header forcing, mid-frame rewrite and collapsed restarts.
      write_px(3'd1, 32'h05AABBCC);
      bits.delete(); done_cyc.delete(); busy_drops = 0;
      pulse_start();
      repeat (400) @(posedge clk);
      #1;
      write_px(3'd0, 32'hFF123456);
      pulse_start();
      repeat (10) @(posedge clk);
      #1;
      pulse_start();
      repeat (10) @(posedge clk);
      #1;
      pulse_start();
      wait_done(2, 5000);
      check("t4_edges", bits.size(), 640);
      check("t3_led0_unchanged", word_at(1), 32'hFF0000FF);
      check("t2_led1_hdr", word_at(2), 32'hE5AABBCC);
      check("t4_end1", word_at(9), 32'hFFFF_FFFF);
      check("t4_start2", word_at(10), 32'h0000_0000);
      check("t3_led0_new", word_at(11), 32'hFF123456);
      check("t4_led1_f2", word_at(12), 32'hE5AABBCC);
      check("t4_end2", word_at(19), 32'hFFFF_FFFF);
      check("t4_gap", (done_cyc.size() >= 2) ? done_cyc[1] - done_cyc[0] : -1, 1281);
      check("t4_busy_drops", busy_drops, 1);
      repeat (50) @(posedge clk);
      #1;
      check("t4_done_total", done_cyc.size(), 2);

      // Reset in the middle of a frame.
      bits.delete(); done_cyc.delete();
      pulse_start();
      n = 0;
      while (bits.size() < 100 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t5_reach_bit100", bits.size(), 100);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("t5_sclk", sclk, 0);
      check("t5_sdata", sdata, 0);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("t5_no_done", done_cyc.size(), 0);
      bits.delete();
      pulse_start();
      wait_done(1, 3000);
      check("t5_edges", bits.size(), 320);
      for (int w = 1; w <= 8; w++) check($sformatf("t5_led%0d", w - 1), word_at(w), 32'hE000_0000);
      @(posedge clk); #1;

      // Out-of-range writes on a 6-LED chain at CLK_DIV=1.
      write_px6(3'd6, 32'hFFFF_FFFF);
      write_px6(3'd7, 32'hFFFF_FFFF);
      write_px6(3'd5, 32'h0000_0001);
      bits6.delete();
      start6 = 1'b1;
      @(posedge clk); #1;
      start6 = 1'b0;
      n = 0;
      while (done6_n < 1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t6_done", done6_n, 1);
      check("t6_edges", bits6.size(), 256);
      check("t6_start_frm", word6_at(0), 32'h0000_0000);
      for (int w = 1; w <= 5; w++) check($sformatf("t6_led%0d", w - 1), word6_at(w), 32'hE000_0000);
      check("t6_led5", word6_at(6), 32'hE000_0001);
      check("t6_end_frm", word6_at(7), 32'hFFFF_FFFF);
      check("t6_toggle", notoggle6, 0);
      check("t6_len", busy6_cycles, 512);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
